// File: rtl/led_show_scheduler.sv
// led_show_scheduler: fixed-priority owner arbitration of the 16-bit LED bar with a tick-paced pattern player
//   clk       system clock
//   rst       asynchronous active-high reset
//   cube_num  cube count shown as a bar graph while idle
//   req       level requests: [0] chase, [1] blink, [2] checker (checker highest)
//   grant     one-hot current owner, 000 when idle
//   busy      high in RUN or DONE
//   done      one-cycle pulse when a grant completes
//   led       LED bar drive
// Optional: define LED_SHOW_PREEMPT_EN to let a higher-priority request abort a running pattern.
module led_show_scheduler #(
   parameter int TICK_DIV   = 10_000_000,
   parameter int HOLD_TICKS = 8,
   parameter int CNT_W      = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  cube_num,
   input  logic [2:0]  req,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        done,
   output logic [15:0] led
);
   localparam int SW = $clog2(HOLD_TICKS + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [2:0] grant_n, top;
   logic [CNT_W-1:0] tcnt, tcnt_n;
   logic [SW-1:0] step, step_n;
   logic [15:0] led_n, therm, init, adv;
   logic tick, preempt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= 3'b000;
         tcnt  <= '0;
         step  <= '0;
         led   <= 16'h0000;
      end else begin
         state <= state_n;
         grant <= grant_n;
         tcnt  <= tcnt_n;
         step  <= step_n;
         led   <= led_n;
      end
   end
   always_comb begin
      top   = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
      therm = cube_num >= 7'd16 ? 16'hFFFF : 16'((17'd1 << cube_num[3:0]) - 17'd1);
      init  = top[2] ? 16'hAAAA : top[1] ? 16'hFFFF : 16'h0001;
      // chase rotates; blink and checker alternate with their complement
      adv   = grant[0] ? {led[14:0], led[15]} : ~led;
      tick  = tcnt == CNT_W'(TICK_DIV - 1);
`ifdef LED_SHOW_PREEMPT_EN
      // one-hot values compare in priority order
      preempt = state == RUN && top > grant;
`else
      preempt = 1'b0;
`endif
      state_n = state;
      grant_n = grant;
      tcnt_n  = '0;
      step_n  = step;
      led_n   = led;
      if (preempt) begin
         grant_n = top;
         step_n  = '0;
         led_n   = init;
      end else if (state == IDLE) begin
         step_n = '0;
         if (|req) begin
            state_n = RUN;
            grant_n = top;
            led_n   = init;
         end else
            led_n = therm;
      end else if (state == RUN) begin
         tcnt_n = tick ? '0 : tcnt + CNT_W'(1);
         if (tick && step == SW'(HOLD_TICKS - 1))
            state_n = DONE;
         else if (tick) begin
            step_n = step + SW'(1);
            led_n  = adv;
         end
      end else begin
         state_n = IDLE;
         grant_n = 3'b000;
         step_n  = '0;
      end
   end
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
   end
endmodule

// File: tb/tb_led_show_scheduler.sv
// tb_led_show_scheduler: random and directed stimulus against a run-timeline model of the LED scheduler
module tb_led_show_scheduler;
   localparam int T = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [6:0] cube = 7'd0;
   logic [2:0] req = 3'b000, req2 = 3'b000;
   logic [2:0] gr[2];
   logic bz[2], dn[2];
   logic [15:0] ld[2];
   int vec = 0, bad = 0;
   int ms[2], mo[2], ma[2];
   logic [15:0] ml[2];
   int ht[2] = '{3, 17};

   always #5 clk = ~clk;

   led_show_scheduler #(.TICK_DIV(T), .HOLD_TICKS(3), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .cube_num(cube), .req(req),
      .grant(gr[0]), .busy(bz[0]), .done(dn[0]), .led(ld[0]));
   led_show_scheduler #(.TICK_DIV(T), .HOLD_TICKS(17), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .cube_num(cube), .req(req2),
      .grant(gr[1]), .busy(bz[1]), .done(dn[1]), .led(ld[1]));

   function automatic logic [15:0] pat(int o, int k);
      if (o == 0) return 16'(32'd1 << (k % 16));
      if (o == 1) return (k % 2) ? 16'h0000 : 16'hFFFF;
      return (k % 2) ? 16'h5555 : 16'hAAAA;
   endfunction
   function automatic logic [15:0] therm(int n);
      return n >= 16 ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
   endfunction
   function automatic int hi(logic [2:0] r);
      return r[2] ? 2 : r[1] ? 1 : r[0] ? 0 : -1;
   endfunction

   // ms: 0 idle, 1 run, 2 done; ma = cycles since the grant started
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            ms[i] <= 0; mo[i] <= 0; ma[i] <= 0; ml[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            logic [2:0] r;
            r = i ? req2 : req;
            if (ms[i] == 0) begin
               if (r != 0) begin
                  ms[i] <= 1; mo[i] <= hi(r); ma[i] <= 0; ml[i] <= pat(hi(r), 0);
               end else
                  ml[i] <= therm(int'(cube));
            end else if (ms[i] == 1) begin
`ifdef LED_SHOW_PREEMPT_EN
               if (hi(r) > mo[i]) begin
                  mo[i] <= hi(r); ma[i] <= 0; ml[i] <= pat(hi(r), 0);
               end else
`endif
               begin
                  ma[i] <= ma[i] + 1;
                  if (ma[i] + 1 == ht[i] * T) ms[i] <= 2;
                  else ml[i] <= pat(mo[i], (ma[i] + 1) / T);
               end
            end else
               ms[i] <= 0;
         end
      end
   end

   task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
      vec++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("grant%0d", i), 16'(gr[i]), ms[i] == 0 ? 16'h0 : 16'(32'd1 << mo[i]));
         chk($sformatf("busy%0d", i), 16'(bz[i]), 16'(ms[i] != 0));
         chk($sformatf("done%0d", i), 16'(dn[i]), 16'(ms[i] == 2));
         chk($sformatf("led%0d", i), ld[i], ml[i]);
      end
   end

   task automatic nx();
      @(negedge clk);
   endtask
   task automatic skip(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_idle();
      int k = 0;
      while ((bz[0] || bz[1]) && k < 300) begin
         nx();
         k++;
      end
      chk("idle_timeout", 16'(bz[0] | bz[1]), 16'h0);
      nx();
   endtask

   initial begin
      int c;
      #1 rst = 1'b1;
      skip(2);
      chk("rst_led", ld[0], 16'h0000);
      chk("rst_grant", 16'(gr[0]), 16'h0);
      #1 rst = 1'b0; cube = 7'd5;
      nx();
      chk("bar5", ld[0], 16'h001F);
      // chase pulse
      #1 req = 3'b001;
      nx();
      chk("chase_grant", 16'(gr[0]), 16'h0001);
      chk("chase_s0", ld[0], 16'h0001);
      #1 req = 3'b000;
      skip(4);
      chk("chase_s1", ld[0], 16'h0002);
      skip(4);
      chk("chase_s2", ld[0], 16'h0004);
      skip(4);
      chk("chase_done", 16'(dn[0]), 16'h1);
      nx();
      chk("chase_ungrant", 16'(gr[0]), 16'h0);
      chk("chase_hold", ld[0], 16'h0004);
      nx();
      chk("chase_bar", ld[0], 16'h001F);
      // priority
      #1 req = 3'b011;
      nx();
      chk("prio_grant", 16'(gr[0]), 16'h0002);
      chk("prio_s0", ld[0], 16'hFFFF);
      #1 req = 3'b000;
      c = bz[0] ? 1 : 0;
      for (int j = 1; j < 20; j++) begin
         nx();
         if (bz[0]) c++;
         if (j == 4) chk("prio_s1", ld[0], 16'h0000);
         if (j == 8) chk("prio_s2", ld[0], 16'hFFFF);
      end
      chk("prio_busy_len", 16'(c), 16'd13);
      // saturation
      #1 cube = 7'd0;
      nx();
      chk("bar0", ld[0], 16'h0000);
      #1 cube = 7'd16;
      nx();
      chk("bar16", ld[0], 16'hFFFF);
      #1 cube = 7'd100;
      nx();
      chk("bar100", ld[0], 16'hFFFF);
      #1 cube = 7'd9;
      nx();
      chk("bar9", ld[0], 16'h01FF);
      // chase wrap on the 17-step instance
      #1 req2 = 3'b001;
      nx();
      chk("wrap_s0", ld[1], 16'h0001);
      #1 req2 = 3'b000;
      skip(60);
      chk("wrap_s15", ld[1], 16'h8000);
      skip(4);
      chk("wrap_s16", ld[1], 16'h0001);
      wait_idle();
      // back-to-back checker
      #1 req = 3'b100;
      c = 0;
      while (!dn[0] && c < 40) begin
         nx();
         c++;
      end
      chk("b2b_done", 16'(dn[0]), 16'h1);
      nx();
      chk("b2b_gap", 16'(gr[0]), 16'h0);
      nx();
      chk("b2b_regrant", 16'(gr[0]), 16'h0004);
      chk("b2b_led", ld[0], 16'hAAAA);
      #1 req = 3'b000;
      wait_idle();
      // higher-priority request during a chase
      #1 req = 3'b001;
      nx();
      #1 req = 3'b000;
      skip(4);
      #1 req = 3'b100;
      nx();
`ifdef LED_SHOW_PREEMPT_EN
      chk("pre_grant", 16'(gr[0]), 16'h0004);
      chk("pre_led", ld[0], 16'hAAAA);
      #1 req = 3'b000;
      c = 0;
      repeat (11) begin
         nx();
         if (dn[0]) c++;
      end
      chk("pre_nodone", 16'(c), 16'h0);
      nx();
      chk("pre_done", 16'(dn[0]), 16'h1);
`else
      skip(7);
      chk("nopre_done", 16'(dn[0]), 16'h1);
      chk("nopre_grant", 16'(gr[0]), 16'h0001);
      nx();
      chk("nopre_gap", 16'(gr[0]), 16'h0);
      nx();
      chk("nopre_next", 16'(gr[0]), 16'h0004);
      chk("nopre_led", ld[0], 16'hAAAA);
      #1 req = 3'b000;
`endif
      wait_idle();
      // asynchronous reset mid-run
      #1 req = 3'b010;
      nx();
      #1 req = 3'b000;
      skip(3);
      #2 rst = 1'b1;
      #1;
      chk("arst_grant", 16'(gr[0]), 16'h0);
      chk("arst_busy", 16'(bz[0]), 16'h0);
      chk("arst_done", 16'(dn[0]), 16'h0);
      chk("arst_led", ld[0], 16'h0000);
      nx();
      #1 rst = 1'b0; cube = 7'd5;
      nx();
      chk("arst_bar", ld[0], 16'h001F);
      // random traffic
      for (int n = 0; n < 4000; n++) begin
         nx();
         #1;
         if ($urandom_range(0, 3) == 0) req = 3'($urandom);
         if ($urandom_range(0, 15) == 0) req2 = 3'($urandom);
         if ($urandom_range(0, 2) == 0)
            cube = $urandom_range(0, 1) ? 7'($urandom_range(0, 17)) : 7'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      req = 3'b000;
      req2 = 3'b000;
      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
